seq_mul_booth: RTL and testbench

SEQ_MUL_BOOTH -- requirements
Module: seq_mul_booth

---
 rtl/seq_mul_booth.sv | 125 ++++++++++++
 tb/tb_seq_mul_booth.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_booth.sv
// Sequential radix-2 Booth signed multiplier with fixed-point scaling and overflow flag.
// Define SEQ_MUL_SAT_EN to clamp out_o on overflow; otherwise the result wraps.
module seq_mul_booth #(
  parameter int A_W        = 8,
  parameter int B_W        = 8,
  parameter int OUT_W      = 8,
  parameter int FRAC_SHIFT = 0,
  parameter int CLK_DIV    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [OUT_W-1:0] out_o,
  output logic             ovf_o
);

  localparam int PW    = A_W + B_W;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(B_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [A_W-1:0]   a_q;
  logic [A_W:0]     acc;
  logic [B_W-1:0]   q;
  logic             q_m1;
  logic [CNT_W-1:0] step_cnt;
  logic [DIV_W-1:0] div_cnt;

  logic             step_en, last_step;
  logic [A_W:0]     a_ext, sum;
  logic [PW-1:0]    prod, scaled;
  logic [OUT_W-1:0] res;
  logic             res_ovf;

  assign step_en   = (state == RUN) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_step = step_en && (step_cnt == CNT_W'(B_W - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_i) state_next = RUN;
      RUN: begin
        if (start_i)        state_next = RUN;
        else if (last_step) state_next = DONE;
      end
      DONE: state_next = start_i ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == RUN);
    done_o = (state == DONE);
  end

  // One Booth step plus the following arithmetic shift; the shifted {acc, q}
  // after the final step is exactly {sum, q[B_W-1:1]} in its low PW bits.
  always_comb begin
    a_ext = {a_q[A_W-1], a_q};
    case ({q[0], q_m1})
      2'b10:   sum = acc - a_ext;
      2'b01:   sum = acc + a_ext;
      default: sum = acc;
    endcase
    prod   = {sum, q[B_W-1:1]};
    scaled = $signed(prod) >>> FRAC_SHIFT;
  end

  always_comb begin
    res_ovf = 1'b0;
    for (int unsigned i = OUT_W; i < PW; i++) begin
      if (scaled[i] != scaled[OUT_W-1]) res_ovf = 1'b1;
    end
    res = scaled[OUT_W-1:0];
`ifdef SEQ_MUL_SAT_EN
    if (res_ovf) res = scaled[PW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      step_cnt <= '0;
      div_cnt  <= '0;
      out_o    <= '0;
      ovf_o    <= 1'b0;
    end else if (start_i) begin
      a_q      <= a_i;
      q        <= b_i;
      acc      <= '0;
      q_m1     <= 1'b0;
      step_cnt <= '0;
      div_cnt  <= '0;
    end else if (state == RUN) begin
      if (step_en) begin
        div_cnt  <= '0;
        acc      <= {sum[A_W], sum[A_W:1]};
        q        <= {sum[0], q[B_W-1:1]};
        q_m1     <= q[0];
        step_cnt <= step_cnt + 1'b1;
        if (last_step) begin
          out_o <= res;
          ovf_o <= res_ovf;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_booth.sv
// Self-checking bench for seq_mul_booth: table vectors, abort/reset/back-to-back
// sequences, and a fixed-point instance; expected results queued per start.
module tb_seq_mul_booth;

  localparam int A_W = 8, B_W = 8, OUT_W = 8, CLK_DIV = 4;
  localparam int LAT = B_W * CLK_DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, busy, done, ovf;
  logic [7:0] a, b, out;
  logic       start2, busy2, done2, ovf2;
  logic [7:0] a2, b2, out2;

  seq_mul_booth #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .FRAC_SHIFT(0), .CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .out_o(out), .ovf_o(ovf)
  );

  seq_mul_booth #(.A_W(8), .B_W(8), .OUT_W(8), .FRAC_SHIFT(4), .CLK_DIV(1)) dut_fx (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .a_i(a2), .b_i(b2),
    .busy_o(busy2), .done_o(done2), .out_o(out2), .ovf_o(ovf2)
  );

  typedef struct {
    logic [7:0] out;
    logic       ovf;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out_wrap;
    logic [7:0] out_sat;
    logic       ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks = 0, errors = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb);
    exp_t        e;
    int          p;
    logic [31:0] pv;
    p  = $signed(ma) * $signed(mb);
    pv = p;
    e.ovf = (p > 127) || (p < -128);
    e.out = pv[7:0];
`ifdef SEQ_MUL_SAT_EN
    if (e.ovf) e.out = (p < 0) ? 8'h80 : 8'h7F;
`endif
    e.due = 0;
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
`ifdef SEQ_MUL_SAT_EN
    e.out = v.out_sat;
`else
    e.out = v.out_wrap;
`endif
    e.ovf = v.ovf;
    e.due = 0;
    return e;
  endfunction

  // Advance one clock, sample just after the edge, and score any completion.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.due);
        check("out", {24'd0, out}, {24'd0, e.out});
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      checks++;
      errors++;
      $display("FAIL missing_done: got no done_o expected one at cycle %0d (cycle %0d)", sb[0].due, cyc);
      sb.delete(0);
    end
  endtask

  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input exp_t e);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    e.due = cyc + 1 + LAT;
    sb.push_back(e);
    start = 1'b1;
    a     = ia;
    b     = ib;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0 (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  initial begin
    int   n, bc, dc;
    vec_t v;

    vecs[0]  = '{8'h05, 8'hFD, 8'hF1, 8'hF1, 1'b0};
    vecs[1]  = '{8'h80, 8'h80, 8'h00, 8'h7F, 1'b1};
    vecs[2]  = '{8'h80, 8'h01, 8'h80, 8'h80, 1'b0};
    vecs[3]  = '{8'h07, 8'h07, 8'h31, 8'h31, 1'b0};
    vecs[4]  = '{8'h7F, 8'h7F, 8'h01, 8'h7F, 1'b1};
    vecs[5]  = '{8'h80, 8'h7F, 8'h80, 8'h80, 1'b1};
    vecs[6]  = '{8'h00, 8'h80, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{8'hFF, 8'hFF, 8'h01, 8'h01, 1'b0};
    vecs[8]  = '{8'h0B, 8'hF5, 8'h87, 8'h87, 1'b0};
    vecs[9]  = '{8'h10, 8'h08, 8'h80, 8'h7F, 1'b1};
    vecs[10] = '{8'hF0, 8'h08, 8'h80, 8'h80, 1'b0};
    vecs[11] = '{8'h7F, 8'hFF, 8'h81, 8'h81, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    tick(); tick();
    start = 1'b1; a = 8'h05; b = 8'h05;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_out", {24'd0, out}, 32'd0);
    check("reset_ovf", {31'd0, ovf}, 32'd0);

    // 5 * -3 with busy window measurement
    start_op(8'h05, 8'hFD, from_vec(vecs[0]));
    bc = busy ? 1 : 0;
    n = 0;
    while (sb.size() > 0 && n < LAT + 8) begin
      tick();
      n++;
      if (done) check("busy_in_done", {31'd0, busy}, 32'd0);
      else if (busy) bc++;
    end
    check("busy_cycles", bc, LAT);
    drain(4);
    tick();

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      start_op(v.a, v.b, from_vec(v));
      drain(LAT + 8);
      tick();
    end

    // Restart accepted in the done cycle: completion still scored, new op follows
    start_op(8'h03, 8'h05, model(8'h03, 8'h05));
    drain(LAT + 8);
    start_op(8'hF9, 8'h09, model(8'hF9, 8'h09));
    drain(LAT + 8);
    tick();

    // Abort: 3*4 then 7*7 ten cycles later; only 7*7 completes
    start_op(8'h03, 8'h04, model(8'h03, 8'h04));
    for (int i = 0; i < 9; i++) tick();
    start_op(8'h07, 8'h07, from_vec(vecs[3]));
    drain(LAT + 8);
    tick();

    // Reset mid-operation clears outputs and suppresses completion
    start_op(8'h06, 8'h06, model(8'h06, 8'h06));
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("rst_run_busy", {31'd0, busy}, 32'd0);
    check("rst_run_done", {31'd0, done}, 32'd0);
    check("rst_run_out", {24'd0, out}, 32'd0);
    check("rst_run_ovf", {31'd0, ovf}, 32'd0);
    dc = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (done || busy) dc++;
    end
    check("rst_quiet", dc, 0);

    for (int i = 0; i < 16; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      start_op(ra, rb, model(ra, rb));
      drain(LAT + 8);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end

    // Fixed-point instance: 3.0 * 2.5 in Q4.4, one step per clock
    a2 = 8'h30; b2 = 8'h28; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 50) begin
      tick();
      n++;
    end
    check("fx_latency", n, 8);
    check("fx_out", {24'd0, out2}, 32'h78);
    check("fx_ovf", {31'd0, ovf2}, 32'd0);
    tick();
    check("fx_done_width", {31'd0, done2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
